// File: rtl/demux_pkg.sv
// demux_pkg
// Shared definitions for the registered 1-to-N demultiplexer:
//   MODE_EXPL / MODE_AUTO  encodings of the mode input
//   demux_state_e          sequencing state that follows the registered mode
//   lane_in_range()        true when a select value addresses an existing lane
package demux_pkg;

  localparam logic MODE_EXPL = 1'b0;
  localparam logic MODE_AUTO = 1'b1;

  typedef enum logic {
    ST_EXPL = 1'b0,
    ST_AUTO = 1'b1
  } demux_state_e;

  // When N is not a power of two some select codes point past the last lane.
  function automatic logic lane_in_range(input int unsigned sel, input int unsigned n);
    return sel < n;
  endfunction

endpackage

// File: rtl/demux_rr_ptr.sv
// demux_rr_ptr
// Round-robin lane pointer for auto mode.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset (pointer -> 0)
//   clr_i      synchronous clear (pointer -> 0), wins over everything
//   restart_i  mode changed this cycle: pointer restarts from lane 0
//   inc_i      auto-mode write accepted: advance past the lane just written
//   ptr_o      current pointer (lane used by the next auto write)
module demux_rr_ptr
  import demux_pkg::*;
#(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          restart_i,
  input  logic          inc_i,
  output logic [SW-1:0] ptr_o
);

  localparam logic [SW-1:0] LAST = SW'(N - 1);

  logic [SW-1:0] ptr_q;
  logic [SW-1:0] ptr_d;
  logic [SW-1:0] base;

  // On a mode change the write in that same cycle already uses lane 0, so
  // the increment is applied to the restarted value, not the stale pointer.
  // Wrapping compares against N-1 explicitly so codes >= N never appear.
  always_comb begin
    base  = restart_i ? '0 : ptr_q;
    ptr_d = base;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = (base == LAST) ? '0 : base + SW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/demux_1ton_reg.sv
// demux_1ton_reg
// Registered 1-to-N demultiplexer. Each accepted word is written into one
// lane register which then holds until rewritten or cleared. Explicit mode
// steers by S; auto mode walks lanes round-robin and so rebuilds a frame
// that an upstream mux serialised.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   clr          synchronous clear of lanes, pointer and strobes
//   mode         0 = explicit select (S), 1 = auto round-robin
//   in_valid, D  write strobe and data word
//   S            target lane in explicit mode
//   Y            lane registers, lane k = Y[k*W +: W]
//   Y_valid      one-cycle strobe per lane written
//   frame_done   one-cycle pulse when auto mode writes lane N-1
//   ptr          auto-mode pointer
//   sel_err      one-cycle pulse on a dropped out-of-range explicit write
// Build option: define DEMUX_ERR_EN to drive sel_err; otherwise it is tied 0.
module demux_1ton_reg
  import demux_pkg::*;
#(
  parameter int N  = 8,
  parameter int W  = 1,
  parameter int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            mode,
  input  logic            in_valid,
  input  logic [W-1:0]    D,
  input  logic [SW-1:0]   S,
  output logic [N*W-1:0]  Y,
  output logic [N-1:0]    Y_valid,
  output logic            frame_done,
  output logic [SW-1:0]   ptr,
  output logic            sel_err
);

  localparam logic [SW-1:0] LAST = SW'(N - 1);

  demux_state_e  state_q;
  logic          modeChange;
  logic          autoNow;
  logic          inRange;
  logic          writeEn;
  logic [SW-1:0] laneSel;
  logic          frameDone_q;

  // Sequencing state simply follows the mode input one cycle late; the
  // difference between the two is what marks a mode change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EXPL;
    end else begin
      case (state_q)
        ST_EXPL: if (mode == MODE_AUTO) state_q <= ST_AUTO;
        ST_AUTO: if (mode == MODE_EXPL) state_q <= ST_EXPL;
      endcase
    end
  end

  // A write in the cycle of a mode change already follows the new mode and,
  // in auto mode, lands on lane 0 because the pointer is restarting.
  always_comb begin
    autoNow    = (mode == MODE_AUTO);
    modeChange = autoNow != (state_q == ST_AUTO);
    laneSel    = autoNow ? (modeChange ? '0 : ptr) : S;
    inRange    = autoNow || lane_in_range(32'(S), N);
    writeEn    = in_valid && !clr && inRange;
  end

  demux_rr_ptr #(.N(N), .SW(SW)) u_ptr (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (clr),
    .restart_i (modeChange),
    .inc_i     (writeEn && autoNow),
    .ptr_o     (ptr)
  );

  for (genvar k = 0; k < N; k++) begin : g_lane
    localparam logic [SW-1:0] K = SW'(k);
    logic [W-1:0] lane_q;
    logic         valid_q;
    logic         hit;

    assign hit = writeEn && (laneSel == K);

    // clr needs no special case for the strobe: writeEn is already low.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        lane_q  <= '0;
        valid_q <= 1'b0;
      end else if (clr) begin
        lane_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        if (hit) lane_q <= D;
        valid_q <= hit;
      end
    end

    assign Y[k*W +: W] = lane_q;
    assign Y_valid[k]  = valid_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frameDone_q <= 1'b0;
    end else begin
      frameDone_q <= writeEn && autoNow && (laneSel == LAST);
    end
  end

  assign frame_done = frameDone_q;

`ifdef DEMUX_ERR_EN
  logic selErr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      selErr_q <= 1'b0;
    end else begin
      selErr_q <= in_valid && !clr && !inRange;
    end
  end

  assign sel_err = selErr_q;
`else
  assign sel_err = 1'b0;
`endif

endmodule
